// File: rtl/seq_divider_if.sv
// Request/result bundle for the iterative divider: operands and start from the
// requester, status, quotient, remainder and flags back from the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             zero_flag;
  logic             div_zero_flag;
  logic             over_flow_flag;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, zero_flag, div_zero_flag, over_flow_flag
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, zero_flag, div_zero_flag, over_flow_flag
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift/subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; default is unsigned.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             last_s;
  logic             div0_s;

  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [CNT_W-1:0] count_r;

  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH+1:0] diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quo_step_s;
  logic [WIDTH-1:0] fin_q_s;
  logic [WIDTH-1:0] fin_r_s;
  logic             fin_ovf_s;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             zero_r;
  logic             dz_r;
  logic             ovf_r;

  assign div0_s = (bus.B == {WIDTH{1'b0}});

  // One trial subtraction; the extra top bit keeps the shifted-out remainder bit.
  assign shift_s    = {rem_r, dvd_r[WIDTH-1]};
  assign diff_s     = {1'b0, shift_s} - {2'b00, dvs_r};
  assign ge_s       = ~diff_s[WIDTH+1];
  assign rem_step_s = ge_s ? WIDTH'(diff_s) : WIDTH'(shift_s);
  assign quo_step_s = {quo_r[WIDTH-2:0], ge_s};

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic q_neg_r;
  logic r_neg_r;
  logic ovf_pend_r;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign mag_a_s   = bus.A[WIDTH-1] ? twos_neg(bus.A) : bus.A;
  assign mag_b_s   = bus.B[WIDTH-1] ? twos_neg(bus.B) : bus.B;
  assign fin_q_s   = q_neg_r ? twos_neg(quo_step_s) : quo_step_s;
  assign fin_r_s   = r_neg_r ? twos_neg(rem_step_s) : rem_step_s;
  assign fin_ovf_s = ovf_pend_r;

  // Operand signs captured at accept and applied when the result is stored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      ovf_pend_r <= 1'b0;
    end else if (accept_s) begin
      q_neg_r    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
      r_neg_r    <= bus.A[WIDTH-1];
      ovf_pend_r <= (bus.A == MOST_NEG) && (bus.B == {WIDTH{1'b1}});
    end
  end
`else
  assign mag_a_s   = bus.A;
  assign mag_b_s   = bus.B;
  assign fin_q_s   = quo_step_s;
  assign fin_r_s   = rem_step_s;
  assign fin_ovf_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a zero divisor skips iteration and finishes at once.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = div0_s ? DONE : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == CNT_W'(1)) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Iteration datapath: load magnitudes on accept, then shift/subtract per cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dvd_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      dvd_r   <= mag_a_s;
      dvs_r   <= mag_b_s;
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      count_r <= CNT_W'(WIDTH);
    end else if (state_r == CALC) begin
      dvd_r   <= {dvd_r[WIDTH-2:0], 1'b0};
      rem_r   <= rem_step_s;
      quo_r   <= quo_step_s;
      count_r <= count_r - CNT_W'(1);
    end
  end

  // Result and status registers; the last iteration feeds the outputs directly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= {WIDTH{1'b0}};
      r_r    <= {WIDTH{1'b0}};
      zero_r <= 1'b1;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == CALC);
      done_r <= (state_nxt_s == DONE);
      if (accept_s && div0_s) begin
        q_r    <= {WIDTH{1'b1}};
        r_r    <= bus.A;
        zero_r <= 1'b0;
        dz_r   <= 1'b1;
        ovf_r  <= 1'b0;
      end else if (last_s) begin
        q_r    <= fin_q_s;
        r_r    <= fin_r_s;
        zero_r <= (fin_q_s == {WIDTH{1'b0}});
        dz_r   <= 1'b0;
        ovf_r  <= fin_ovf_s;
      end
    end
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.Q              = q_r;
  assign bus.R              = r_r;
  assign bus.zero_flag      = zero_r;
  assign bus.div_zero_flag  = dz_r;
  assign bus.over_flow_flag = ovf_r;

endmodule
